// File: rtl/i2c_slave.sv
// I2C slave with one fixed 7-bit address and a single 8-bit data register.
// SCL/SDA are oversampled by clk; SDA is driven open-drain through sda_out.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'h51
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_out,
  output logic [7:0] data
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StWrite,
    StWriteAck,
    StRead,
    StReadAck,
    StWaitStop
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sreg_q, sreg_d;
  logic [7:0] data_q, data_d;
  logic       sda_out_q, sda_out_d;
  logic       rw_q, rw_d;

  logic scl_meta_q, scl_sync_q, scl_hist_q;
  logic sda_meta_q, sda_sync_q, sda_hist_q;

  logic scl_rise, scl_fall, start_det, stop_det;

  // Synchronisers reset to the idle-bus level so reset release cannot fake a START.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_hist_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_hist_q <= 1'b1;
    end else begin
      scl_meta_q <= scl;
      scl_sync_q <= scl_meta_q;
      scl_hist_q <= scl_sync_q;
      sda_meta_q <= sda_in;
      sda_sync_q <= sda_meta_q;
      sda_hist_q <= sda_sync_q;
    end
  end

  assign scl_rise  = scl_sync_q & ~scl_hist_q;
  assign scl_fall  = ~scl_sync_q & scl_hist_q;
  assign start_det = ~sda_sync_q & sda_hist_q & scl_sync_q;
  assign stop_det  = sda_sync_q & ~sda_hist_q & scl_sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      sreg_q    <= 8'h00;
      data_q    <= 8'h00;
      sda_out_q <= 1'b1;
      rw_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sreg_q    <= sreg_d;
      data_q    <= data_d;
      sda_out_q <= sda_out_d;
      rw_q      <= rw_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sreg_d    = sreg_q;
    data_d    = data_q;
    sda_out_d = sda_out_q;
    rw_d      = rw_q;

    if (stop_det) begin
      state_d   = StIdle;
      sda_out_d = 1'b1;
    end else if (start_det) begin
      state_d   = StAddr;
      cnt_d     = 4'd0;
      sda_out_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: ;

        StAddr: begin
          if (scl_rise) begin
            sreg_d = {sreg_q[6:0], sda_sync_q};
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              // sreg_q[6:0] holds the seven address bits; this rise carries R/W.
              rw_d = sda_sync_q;
              if (sreg_q[6:0] != SLAVE_ADDR) begin
                state_d = StWaitStop;
              end
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            sda_out_d = 1'b0;
            state_d   = StAddrAck;
          end
        end

        StAddrAck: begin
          if (scl_fall) begin
            if (rw_q) begin
              sda_out_d = data_q[7];
              sreg_d    = {data_q[6:0], 1'b0};
              cnt_d     = 4'd1;
              state_d   = StRead;
            end else begin
              sda_out_d = 1'b1;
              cnt_d     = 4'd0;
              state_d   = StWrite;
            end
          end
        end

        StWrite: begin
          if (scl_rise) begin
            sreg_d = {sreg_q[6:0], sda_sync_q};
            cnt_d  = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              data_d = {sreg_q[6:0], sda_sync_q};
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            sda_out_d = 1'b0;
            state_d   = StWriteAck;
          end
        end

        StWriteAck: begin
          if (scl_fall) begin
            sda_out_d = 1'b1;
            cnt_d     = 4'd0;
            state_d   = StWrite;
          end
        end

        StRead: begin
          // cnt_q counts bits already placed on the bus.
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_out_d = 1'b1;
              state_d   = StReadAck;
            end else begin
              sda_out_d = sreg_q[7];
              sreg_d    = {sreg_q[6:0], 1'b0};
              cnt_d     = cnt_q + 4'd1;
            end
          end
        end

        StReadAck: begin
          if (scl_rise) begin
            if (sda_sync_q) begin
              state_d = StWaitStop;
            end
          end else if (scl_fall) begin
            sda_out_d = data_q[7];
            sreg_d    = {data_q[6:0], 1'b0};
            cnt_d     = 4'd1;
            state_d   = StRead;
          end
        end

        StWaitStop: ;
      endcase
    end
  end

  assign sda_out = sda_out_q;
  assign data    = data_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged I2C master with a byte-level model of the
// slave's data register and expected ACK/read responses.
module tb_i2c_slave;

  localparam int unsigned Q    = 10;  // clk cycles per quarter SCL period
  localparam logic [6:0]  Addr = 7'h51;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl_m;
  logic       sda_m;
  logic       sda_out;
  logic       sda_line;
  logic [7:0] data;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] model_data;
  logic       ok;
  logic       bit_line, bit_steady;
  logic [7:0] bit_snap;

  // Open-drain bus: either side can pull low.
  assign sda_line = sda_m & sda_out;

  always #10 clk = ~clk;

  i2c_slave #(.SLAVE_ADDR(Addr)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .scl    (scl_m),
    .sda_in (sda_line),
    .sda_out(sda_out),
    .data   (data)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  // One SCL pulse; returns the line value during high, whether it held steady,
  // and the data output four clocks after the rising edge.
  task automatic clock_bit(input logic b, output logic line, output logic steady,
                           output logic [7:0] snap);
    sda_m = b;
    wait_q();
    scl_m  = 1'b1;
    steady = 1'b1;
    line   = 1'b1;
    snap   = 8'h00;
    for (int i = 0; i < 2 * Q; i++) begin
      @(negedge clk);
      if (i == 0) line = sda_line;
      else if (sda_line !== line) steady = 1'b0;
      if (i == 3) snap = data;
    end
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic bus_start();
    sda_m = 1'b1;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b0;
    wait_q();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    wait_q();
    scl_m = 1'b1;
    wait_q();
    sda_m = 1'b1;
    wait_q();
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic       line, steady;
    logic [7:0] snap;
    line = 1'b1;
    steady = 1'b1;
    snap = 8'h00;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], line, steady, snap);
    check({tag, " data"}, snap, model_data);
    clock_bit(1'b1, line, steady, snap);
    check({tag, " ack"}, {6'd0, steady, line}, {6'd0, 1'b1, ~exp_ack});
  endtask

  task automatic read_byte(input logic [7:0] exp_byte, input logic nack, input string tag);
    logic       line, steady, all_steady;
    logic [7:0] got, snap;
    all_steady = 1'b1;
    got = 8'h00;
    line = 1'b1;
    steady = 1'b1;
    snap = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, line, steady, snap);
      got[i] = line;
      all_steady &= steady;
    end
    check({tag, " bits"}, got, exp_byte);
    check({tag, " stable"}, {7'd0, all_steady}, 8'd1);
    check({tag, " data"}, snap, model_data);
    clock_bit(nack, line, steady, snap);
    check({tag, " ack slot"}, {7'd0, line}, {7'd0, nack});
  endtask

  initial begin
    rst_n = 1'b0;
    scl_m = 1'b1;
    sda_m = 1'b1;
    model_data = 8'h00;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset sda_out", {7'd0, sda_out}, 8'd1);
    check("reset data", data, 8'h00);

    ok = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (sda_out !== 1'b1 || data !== 8'h00) ok = 1'b0;
    end
    check("idle bus", {7'd0, ok}, 8'd1);

    // Single write of 0xAE.
    bus_start();
    write_byte({Addr, 1'b0}, 1'b1, "wr1 addr");
    model_data = 8'hAE;
    write_byte(8'hAE, 1'b1, "wr1 byte");
    bus_stop();
    check("wr1 stop release", {7'd0, sda_out}, 8'd1);

    // Wrong address: no ACK anywhere, data unchanged.
    bus_start();
    write_byte({7'h52, 1'b0}, 1'b0, "miss addr");
    write_byte(8'h11, 1'b0, "miss byte");
    bus_stop();
    check("miss data", data, model_data);

    // Write, repeated START, read twice (ACK then NACK).
    bus_start();
    write_byte({Addr, 1'b0}, 1'b1, "rd addr w");
    model_data = 8'hAE;
    write_byte(8'hAE, 1'b1, "rd byte w");
    bus_start();
    write_byte({Addr, 1'b1}, 1'b1, "rd addr r");
    read_byte(8'hAE, 1'b0, "rd1");
    read_byte(8'hAE, 1'b1, "rd2");
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      clock_bit(1'b1, bit_line, bit_steady, bit_snap);
      if (bit_line !== 1'b1 || bit_steady !== 1'b1) ok = 1'b0;
    end
    check("wait_stop released", {7'd0, ok}, 8'd1);
    bus_stop();

    // Two-byte write.
    bus_start();
    write_byte({Addr, 1'b0}, 1'b1, "wr2 addr");
    model_data = 8'h3C;
    write_byte(8'h3C, 1'b1, "wr2 b0");
    model_data = 8'hC3;
    write_byte(8'hC3, 1'b1, "wr2 b1");
    bus_stop();
    check("wr2 final", data, 8'hC3);

    // Reset in the middle of a data byte.
    bus_start();
    write_byte({Addr, 1'b0}, 1'b1, "rst addr");
    for (int i = 7; i >= 4; i--) clock_bit(i[0], bit_line, bit_steady, bit_snap);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    model_data = 8'h00;
    check("midrst data", data, 8'h00);
    check("midrst sda_out", {7'd0, sda_out}, 8'd1);
    bus_stop();
    bus_start();
    write_byte({Addr, 1'b0}, 1'b1, "post rst addr");
    model_data = 8'h5A;
    write_byte(8'h5A, 1'b1, "post rst byte");
    bus_stop();
    check("post rst data", data, 8'h5A);

    // Randomised transactions against the byte-level model.
    for (int t = 0; t < 8; t++) begin
      logic [6:0] a;
      logic       rw, hit;
      logic [7:0] b;
      int         n;
      a   = ($urandom_range(0, 1) == 1) ? Addr : 7'($urandom_range(0, 127));
      hit = (a == Addr);
      rw  = 1'($urandom_range(0, 1));
      n   = int'($urandom_range(1, 3));
      bus_start();
      write_byte({a, rw}, hit, "rnd addr");
      for (int k = 0; k < n; k++) begin
        if (rw) begin
          read_byte(hit ? model_data : 8'hFF, (k == n - 1), "rnd rd");
        end else begin
          b = 8'($urandom);
          if (hit) model_data = b;
          write_byte(b, hit, "rnd wr");
        end
      end
      bus_stop();
      check("rnd stop release", {7'd0, sda_out}, 8'd1);
      check("rnd data", data, model_data);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
